// File: rtl/seg_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : seg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a common-cathode multi-digit
//            7-segment display. One digit is driven per scan slot, round-robin.
//            A packed BCD word is loaded through a valid/ready handshake. It is
//            staged and committed only at frame boundaries or while idle.
// Options  : SEG_SCAN_LZB_EN - when defined, leading zeros are blanked.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 3000,
   parameter int BLANK_CYC = 16,
   parameter int CNT_W     = 24
) (
   input  logic                  hwclk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [4*DIGITS-1:0]   load_bcd,
   input  logic [DIGITS-1:0]     load_dp,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_done
);

   localparam int                 c_idx_w      = $clog2(DIGITS);
   localparam logic [CNT_W-1:0]   c_blank_last = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0]   c_slot_last  = CNT_W'(SCAN_DIV - 1);
   localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nx_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_nx_cnt;
   logic [c_idx_w-1:0]   r_idx;
   logic [c_idx_w-1:0]   w_nx_idx;
   logic                 w_boundary;

   logic [4*DIGITS-1:0]  r_disp_bcd;
   logic [DIGITS-1:0]    r_disp_dp;
   logic [4*DIGITS-1:0]  r_stage_bcd;
   logic [DIGITS-1:0]    r_stage_dp;
   logic                 r_pending;
   logic                 w_accept;
   logic                 w_commit;

   logic [DIGITS-1:0]    w_onehot;
   logic [3:0]           w_nib;
   logic                 w_dp;
   logic [DIGITS-1:0]    w_lz_mask;
   logic                 w_lz;
   logic [7:0]           w_nx_seg;
   logic [DIGITS-1:0]    w_nx_dig;

   // Nibble to a..g segment pattern; non-BCD codes show a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = 7'h7E;
         4'd1:    seg = 7'h30;
         4'd2:    seg = 7'h6D;
         4'd3:    seg = 7'h79;
         4'd4:    seg = 7'h33;
         4'd5:    seg = 7'h5B;
         4'd6:    seg = 7'h5F;
         4'd7:    seg = 7'h70;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h7B;
         default: seg = 7'h01;
      endcase
      return seg;
   endfunction

   // Scan state, slot counter and digit index register.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_nx_state;
         r_cnt   <= w_nx_cnt;
         r_idx   <= w_nx_idx;
      end
   end

   // Next scan state; the counter runs 0..SCAN_DIV-1 across BLANK then DRIVE.
   always_comb begin
      w_nx_state = r_state;
      w_nx_cnt   = r_cnt;
      w_nx_idx   = r_idx;
      w_boundary = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_nx_cnt = '0;
            w_nx_idx = '0;
            if (enable) begin
               w_nx_state = S_BLANK;
            end
         end
         S_BLANK: begin
            if (!enable) begin
               w_nx_state = S_IDLE;
               w_nx_cnt   = '0;
               w_nx_idx   = '0;
            end else begin
               w_nx_cnt = r_cnt + CNT_W'(1);
               if (r_cnt == c_blank_last) begin
                  w_nx_state = S_DRIVE;
               end
            end
         end
         S_DRIVE: begin
            if (!enable) begin
               w_nx_state = S_IDLE;
               w_nx_cnt   = '0;
               w_nx_idx   = '0;
            end else if (r_cnt == c_slot_last) begin
               w_nx_state = S_BLANK;
               w_nx_cnt   = '0;
               if (r_idx == c_idx_last) begin
                  w_nx_idx   = '0;
                  w_boundary = 1'b1;
               end else begin
                  w_nx_idx = r_idx + c_idx_w'(1);
               end
            end else begin
               w_nx_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_nx_state = S_IDLE;
            w_nx_cnt   = '0;
            w_nx_idx   = '0;
         end
      endcase
   end

`ifdef SEG_SCAN_LZB_EN
   // Leading-zero mask: a digit blanks when it and every digit above it is a dark zero.
   always_comb begin
      w_lz_mask             = '0;
      w_lz_mask[DIGITS-1]   = (r_disp_bcd[4*DIGITS-1 -: 4] == 4'd0) && !r_disp_dp[DIGITS-1];
      for (int i = DIGITS - 2; i >= 1; i--) begin
         w_lz_mask[i] = w_lz_mask[i+1] && (r_disp_bcd[4*i +: 4] == 4'd0) && !r_disp_dp[i];
      end
   end
`else
   // Without blanking every digit decodes normally.
   always_comb begin
      w_lz_mask = '0;
   end
`endif

   // Next-cycle digit select and segment pattern, computed from the next state.
   always_comb begin
      w_onehot = '0;
      w_nib    = 4'd0;
      w_dp     = 1'b0;
      w_nx_dig = '1;
      w_nx_seg = 8'h00;
      for (int i = 0; i < DIGITS; i++) begin
         if (c_idx_w'(i) == w_nx_idx) begin
            w_onehot[i] = 1'b1;
            w_nib       = r_disp_bcd[4*i +: 4];
            w_dp        = r_disp_dp[i];
         end
      end
      w_lz = |(w_lz_mask & w_onehot);
      if (w_nx_state == S_DRIVE) begin
         w_nx_dig = ~w_onehot;
         w_nx_seg = w_lz ? 8'h00 : {w_dp, seg_decode(w_nib)};
      end
   end

   // Registered display outputs and frame pulse.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= 8'h00;
         dig_sel    <= '1;
         frame_done <= 1'b0;
      end else begin
         seg_out    <= w_nx_seg;
         dig_sel    <= w_nx_dig;
         frame_done <= w_boundary;
      end
   end

   // Ready is low exactly while a word is pending, so a staged word is never overwritten.
   assign w_accept = load_valid && load_ready;
   assign w_commit = r_pending && ((r_state == S_IDLE) || w_boundary);

   // Staging and display registers with the load handshake.
   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_bcd  <= '0;
         r_disp_dp   <= '0;
         r_stage_bcd <= '0;
         r_stage_dp  <= '0;
         r_pending   <= 1'b0;
         load_ready  <= 1'b1;
      end else begin
         if (w_commit) begin
            r_disp_bcd <= r_stage_bcd;
            r_disp_dp  <= r_stage_dp;
         end
         if (w_accept) begin
            r_stage_bcd <= load_bcd;
            r_stage_dp  <= load_dp;
         end
         r_pending  <= w_accept || (r_pending && !w_commit);
         load_ready <= !(w_accept || (r_pending && !w_commit));
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=20,
//            BLANK_CYC=4) with a time-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

   localparam int c_digits = 4;
   localparam int c_div    = 20;
   localparam int c_blank  = 4;
   localparam int c_frame  = c_digits * c_div;

   logic        hwclk;
   logic        rst_n;
   logic        enable;
   logic        load_valid;
   logic        load_ready;
   logic [15:0] load_bcd;
   logic [3:0]  load_dp;
   logic [7:0]  seg_out;
   logic [3:0]  dig_sel;
   logic        frame_done;

   seg_scan_ctrl #(
      .DIGITS    (c_digits),
      .SCAN_DIV  (c_div),
      .BLANK_CYC (c_blank),
      .CNT_W     (8)
   ) u_dut (
      .hwclk      (hwclk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_bcd   (load_bcd),
      .load_dp    (load_dp),
      .seg_out    (seg_out),
      .dig_sel    (dig_sel),
      .frame_done (frame_done)
   );

   initial hwclk = 1'b0;
   always #5 hwclk = ~hwclk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: time since scanning started; slot and phase follow by division.
   bit          m_active;
   int          m_t;
   logic [15:0] m_disp;
   logic [3:0]  m_disp_dp;
   logic [15:0] m_stage;
   logic [3:0]  m_stage_dp;
   bit          m_pend;
   bit          m_fd;
   bit          m_acc;

   logic [6:0]  seg_tab [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active   = 0;
      m_t        = 0;
      m_disp     = '0;
      m_disp_dp  = '0;
      m_stage    = '0;
      m_stage_dp = '0;
      m_pend     = 0;
      m_fd       = 0;
      m_acc      = 0;
   endtask

   function automatic bit lz_blank(input int slot);
`ifdef SEG_SCAN_LZB_EN
      if (slot == 0) return 0;
      for (int j = slot; j < c_digits; j++) begin
         if (m_disp[4*j +: 4] != 4'd0 || m_disp_dp[j]) return 0;
      end
      return 1;
`else
      return (slot < 0);
`endif
   endfunction

   // One clock edge of the reference behaviour, from inputs sampled at the edge.
   task automatic model_step();
      bit prev_active;
      int prev_t;
      bit boundary;
      bit commit;
      prev_active = m_active;
      prev_t      = m_t;
      boundary    = prev_active && enable && ((prev_t % c_frame) == c_frame - 1);
      commit      = m_pend && (!prev_active || boundary);
      m_acc       = load_valid && !m_pend;
      if (commit) begin
         m_disp    = m_stage;
         m_disp_dp = m_stage_dp;
         m_pend    = 0;
      end
      if (m_acc) begin
         m_stage    = load_bcd;
         m_stage_dp = load_dp;
         m_pend     = 1;
      end
      if (!enable) begin
         m_active = 0;
         m_t      = 0;
      end else if (!prev_active) begin
         m_active = 1;
         m_t      = 0;
      end else begin
         m_t = prev_t + 1;
      end
      m_fd = boundary;
   endtask

   task automatic compare_all();
      logic [7:0] e_seg;
      logic [3:0] e_dig;
      int         slot;
      int         phase;
      e_seg = 8'h00;
      e_dig = 4'hF;
      if (m_active) begin
         slot  = (m_t / c_div) % c_digits;
         phase = m_t % c_div;
         if (phase >= c_blank) begin
            e_dig       = 4'hF;
            e_dig[slot] = 1'b0;
            e_seg       = lz_blank(slot) ? 8'h00 : {m_disp_dp[slot], seg_tab[m_disp[4*slot +: 4]]};
         end
      end
      check("seg_out", 32'(seg_out), 32'(e_seg));
      check("dig_sel", 32'(dig_sel), 32'(e_dig));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("load_ready", 32'(load_ready), 32'(!m_pend));
   endtask

   task automatic tick();
      @(posedge hwclk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_word(input logic [15:0] bcd, input logic [3:0] dp);
      bit done;
      done       = 0;
      load_valid = 1'b1;
      load_bcd   = bcd;
      load_dp    = dp;
      for (int i = 0; i < 4 * c_frame && !done; i++) begin
         tick();
         done = m_acc;
      end
      load_valid = 1'b0;
      if (!done) check("load_timeout", 32'd0, 32'd1);
   endtask

   // Advance until the model sits in a DRIVE window of the given digit.
   task automatic wait_drive(input int slot);
      bit found;
      found = 0;
      for (int i = 0; i < 3 * c_frame && !found; i++) begin
         tick();
         found = m_active && ((m_t / c_div) % c_digits == slot)
                 && (m_t % c_div >= c_blank) && (m_t % c_div < c_div - 2);
      end
      if (!found) check("drive_timeout", 32'd0, 32'd1);
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear at once.
   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_seg", 32'(seg_out), 32'h00);
      check("rst_dig", 32'(dig_sel), 32'hF);
      check("rst_ready", 32'(load_ready), 32'h1);
      check("rst_fd", 32'(frame_done), 32'h0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};
      rst_n      = 1'b0;
      enable     = 1'b0;
      load_valid = 1'b0;
      load_bcd   = '0;
      load_dp    = '0;
      model_reset();
      repeat (3) @(posedge hwclk);
      #1;
      check("reset_seg", 32'(seg_out), 32'h00);
      check("reset_dig", 32'(dig_sel), 32'hF);
      check("reset_ready", 32'(load_ready), 32'h1);
      check("reset_fd", 32'(frame_done), 32'h0);
      rst_n = 1'b1;
      run(3);

      // Idle load then start scanning.
      load_word(16'h1234, 4'b0000);
      run(2);
      enable = 1'b1;
      run(c_blank + 1);
      check("first_drive_dig", 32'(dig_sel), 32'hE);
      check("first_drive_seg", 32'(seg_out), 32'h33);
      run(2 * c_frame);

      // Mid-frame load, then a second word that must wait for the commit.
      wait_drive(1);
      load_word(16'h5678, 4'b0000);
      load_valid = 1'b1;
      load_bcd   = 16'h9999;
      run(c_frame / 2);
      load_valid = 1'b0;
      run(2 * c_frame);

      // Dash for non-BCD nibble and a lit decimal point.
      load_word(16'h00FA, 4'b0010);
      run(2 * c_frame + 10);

      // Leading zeros.
      load_word(16'h0050, 4'b0000);
      run(2 * c_frame + 10);

      // Drop enable in the middle of digit 2, then restart.
      wait_drive(2);
      enable = 1'b0;
      tick();
      check("drop_dig", 32'(dig_sel), 32'hF);
      check("drop_seg", 32'(seg_out), 32'h00);
      enable = 1'b1;
      run(c_blank + 1);
      check("restart_dig", 32'(dig_sel), 32'hE);
      run(c_frame);

      // Reset during a DRIVE window.
      wait_drive(3);
      pulse_reset();
      run(5);

      // Randomized traffic.
      enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 9) < 3) enable = 1'b1;
         load_valid = ($urandom_range(0, 99) < 15);
         load_bcd   = 16'($urandom);
         load_dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         tick();
         if (i == 1700) pulse_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
